rec2: RTL and testbench

REC2 -- requirements
Module: rec2

---
 rtl/rec2_pkg.sv | 28 ++
 rtl/rec_edge.sv | 39 +++
 rtl/rec2.sv | 85 ++++++++
 tb/tb_rec2.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rec2_pkg.sv
// Shared constants and helpers for the receive error counter.
// Holds the counter width, the fault-confinement thresholds, the
// re-entry value and saturation limit, and the majority voters through
// which every register is read so that triplication can be dropped in
// later without touching the read side.
package rec2_pkg;

  localparam int unsigned REC_WIDTH = 8;

  localparam logic [REC_WIDTH-1:0] REC_WARN    = 8'd96;
  localparam logic [REC_WIDTH-1:0] REC_PASSIVE = 8'd128;
  localparam logic [REC_WIDTH-1:0] REC_REENTRY = 8'd119;
  localparam logic [REC_WIDTH-1:0] REC_MAX     = 8'd255;
  localparam logic [REC_WIDTH-1:0] REC_STEP_EG = 8'd8;

  // Bitwise 2-of-3 majority over a counter-wide value.
  function automatic logic [REC_WIDTH-1:0] vote3(input logic [REC_WIDTH-1:0] a,
                                                 input logic [REC_WIDTH-1:0] b,
                                                 input logic [REC_WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Single-bit 2-of-3 majority.
  function automatic logic vote3_bit(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rec_edge.sv
// Turns a (possibly multi-cycle) action level into a single-cycle update
// pulse. The edged flag remembers that the current burst has already been
// served; it drops on the first clock with action low.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   action - OR of all counter requests
//   update - high for the first cycle of each action burst
module rec_edge
  import rec2_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic action,
  output logic update
);

  logic edged_q;
  logic edged_d;
  logic edged_v;

  // Voter insertion point: all three copies are the same register today.
  assign edged_v = vote3_bit(edged_q, edged_q, edged_q);

  always_comb begin
    update  = action & ~edged_v;
    // Set on the serving cycle, held while action stays high, cleared on idle.
    edged_d = action;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      edged_q <= 1'b0;
    end else begin
      edged_q <= edged_d;
    end
  end

endmodule

// File: rtl/rec2.sv
// Receive error counter for the fault-confinement logic.
// One saturating update per request burst, prioritised
// resetcount > incegrec > increc > decrec, with threshold flags decoded
// combinationally from the counter register.
// Ports:
//   clock, reset            - rising-edge clock, async active-low reset
//   increc / incegrec       - +1 / +8 requests from the MAC
//   decrec                  - successful reception, decrement
//   resetcount              - clear request from the fault FSM
//   rec_lt96 / rec_ge96     - below / at-or-above warning limit
//   rec_ge128               - error passive
//   reccount                - current count for the register interface
module rec2
  import rec2_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 increc,
  input  logic                 incegrec,
  input  logic                 decrec,
  input  logic                 resetcount,
  output logic                 rec_lt96,
  output logic                 rec_ge96,
  output logic                 rec_ge128,
  output logic [REC_WIDTH-1:0] reccount
);

  logic                 action;
  logic                 update;
  logic [REC_WIDTH-1:0] count_q;
  logic [REC_WIDTH-1:0] count_d;
  logic [REC_WIDTH-1:0] count_v;
  logic [REC_WIDTH:0]   sum_eg;
  logic [REC_WIDTH:0]   sum_one;

  assign action = increc | incegrec | decrec | resetcount;

  rec_edge u_rec_edge (
    .clock  (clock),
    .reset  (reset),
    .action (action),
    .update (update)
  );

  // Voter insertion point: all three copies are the same register today.
  assign count_v = vote3(count_q, count_q, count_q);

  always_comb begin
    count_d = count_v;
    // Carry bit of the 9-bit sums only selects saturation; it is never stored.
    sum_eg  = {1'b0, count_v} + {1'b0, REC_STEP_EG};
    sum_one = {1'b0, count_v} + 9'd1;
    if (update) begin
      if (resetcount) begin
        count_d = '0;
      end else if (incegrec) begin
        count_d = sum_eg[REC_WIDTH] ? REC_MAX : sum_eg[REC_WIDTH-1:0];
      end else if (increc) begin
        count_d = sum_one[REC_WIDTH] ? REC_MAX : sum_one[REC_WIDTH-1:0];
      end else if (decrec) begin
        if (count_v >= REC_PASSIVE) begin
          count_d = REC_REENTRY;
        end else if (count_v != '0) begin
          count_d = count_v - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    rec_ge96  = (count_v >= REC_WARN);
    rec_lt96  = ~rec_ge96;
    rec_ge128 = (count_v >= REC_PASSIVE);
    reccount  = count_v;
  end

endmodule

// File: tb/tb_rec2.sv
// Self-checking bench for rec2: a behavioural counter model checked every
// cycle, plus literal expectations at the notable points of each scenario.
module tb_rec2;

  logic       clock;
  logic       reset;
  logic       increc;
  logic       incegrec;
  logic       decrec;
  logic       resetcount;
  logic       rec_lt96;
  logic       rec_ge96;
  logic       rec_ge128;
  logic [7:0] reccount;

  int n_checks = 0;
  int n_fail   = 0;

  int m_count = 0;
  bit m_served = 0;

  rec2 dut (
    .clock      (clock),
    .reset      (reset),
    .increc     (increc),
    .incegrec   (incegrec),
    .decrec     (decrec),
    .resetcount (resetcount),
    .rec_lt96   (rec_lt96),
    .rec_ge96   (rec_ge96),
    .rec_ge128  (rec_ge128),
    .reccount   (reccount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one update per burst of requests, highest priority wins.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_count  = 0;
      m_served = 0;
    end else begin
      if ((increc | incegrec | decrec | resetcount) && !m_served) begin
        m_served = 1;
        if (resetcount)    m_count = 0;
        else if (incegrec) m_count = (m_count + 8 > 255) ? 255 : m_count + 8;
        else if (increc)   m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
        else if (decrec) begin
          if (m_count >= 128)  m_count = 119;
          else if (m_count > 0) m_count = m_count - 1;
        end
      end else if (!(increc | incegrec | decrec | resetcount)) begin
        m_served = 0;
      end
    end
  end

  // Per-cycle comparison, well after the active edge.
  always @(posedge clock) begin
    #2;
    chk("model_count", int'(reccount), m_count);
    chk("model_lt96",  int'(rec_lt96), (m_count < 96)  ? 1 : 0);
    chk("model_ge96",  int'(rec_ge96), (m_count >= 96) ? 1 : 0);
    chk("model_ge128", int'(rec_ge128), (m_count >= 128) ? 1 : 0);
  end

  // Drive {resetcount, incegrec, increc, decrec} for n cycles, then idle one.
  task automatic burst(input logic [3:0] v, input int n);
    @(negedge clock);
    {resetcount, incegrec, increc, decrec} = v;
    repeat (n) @(negedge clock);
    {resetcount, incegrec, increc, decrec} = 4'b0000;
    @(negedge clock);
  endtask

  task automatic bursts(input logic [3:0] v, input int k);
    for (int i = 0; i < k; i++) burst(v, 1);
  endtask

  initial begin
    reset = 1'b0;
    {resetcount, incegrec, increc, decrec} = 4'b0000;
    repeat (3) @(negedge clock);
    chk("reset_count", int'(reccount), 0);
    chk("reset_lt96",  int'(rec_lt96), 1);
    chk("reset_ge96",  int'(rec_ge96), 0);
    chk("reset_ge128", int'(rec_ge128), 0);
    reset = 1'b1;

    // Three-cycle increc burst counts once.
    burst(4'b0010, 3);
    chk("inc_burst_once", int'(reccount), 1);
    chk("inc_burst_lt96", int'(rec_lt96), 1);

    // Warning and passive thresholds.
    burst(4'b1000, 1);
    bursts(4'b0100, 12);
    chk("eg12_count", int'(reccount), 96);
    chk("eg12_ge96",  int'(rec_ge96), 1);
    chk("eg12_lt96",  int'(rec_lt96), 0);
    chk("eg12_ge128", int'(rec_ge128), 0);
    bursts(4'b0100, 4);
    chk("eg16_count", int'(reccount), 128);
    chk("eg16_ge128", int'(rec_ge128), 1);

    // Decrement from passive re-enters at 119; decrement at 0 holds.
    bursts(4'b0010, 2);
    chk("at130", int'(reccount), 130);
    burst(4'b0001, 1);
    chk("dec_reentry", int'(reccount), 119);
    chk("dec_reentry_ge128", int'(rec_ge128), 0);
    chk("dec_reentry_ge96",  int'(rec_ge96), 1);
    burst(4'b1000, 1);
    burst(4'b0001, 1);
    chk("dec_at_zero", int'(reccount), 0);

    // Saturation at 255.
    bursts(4'b0100, 31);
    bursts(4'b0010, 2);
    chk("at250", int'(reccount), 250);
    burst(4'b0100, 1);
    chk("eg_sat", int'(reccount), 255);
    burst(4'b0010, 1);
    chk("inc_sat", int'(reccount), 255);
    burst(4'b0100, 1);
    chk("eg_sat2", int'(reccount), 255);

    // Priority.
    burst(4'b1000, 1);
    bursts(4'b0100, 12);
    bursts(4'b0010, 4);
    chk("at100_a", int'(reccount), 100);
    burst(4'b0111, 1);
    chk("prio_eg", int'(reccount), 108);
    burst(4'b1000, 1);
    bursts(4'b0100, 12);
    bursts(4'b0010, 4);
    chk("at100_b", int'(reccount), 100);
    burst(4'b1111, 1);
    chk("prio_reset", int'(reccount), 0);

    // Reset mid-burst re-arms the edge detector.
    bursts(4'b0100, 25);
    chk("at200", int'(reccount), 200);
    @(negedge clock);
    increc = 1'b1;
    repeat (2) @(negedge clock);
    chk("held_inc_once", int'(reccount), 201);
    reset = 1'b0;
    #1;
    chk("async_reset", int'(reccount), 0);
    chk("async_reset_lt96", int'(rec_lt96), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("recount_after_reset", int'(reccount), 1);
    repeat (3) @(negedge clock);
    chk("held_after_reset", int'(reccount), 1);
    increc = 1'b0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
